vga_draw_sched: RTL and testbench
=================================

VGA_DRAW_SCHED -- requirements
Module: vga_draw_sched

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 16'hFFFF, write address driven when no beat is granted (scratch byte, never displayed).
REQ-002 SHALL have parameter MAZE_END, default 63360, first address outside the maze region.
REQ-003 SHALL have parameter SCORE_END, default 63808, first address outside the score region.
REQ-004 SHALL have one clock and a synchronous active-high reset.
REQ-005 clk  in  1  system clock, also clocks the frame RAM.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 buf_sel  in  1  writeEnable from vga_ram; either edge marks a buffer swap.
REQ-008 req_valid  in  3  per-requester beat valid; index 0 is maze, 1 is sprite, 2 is score.
REQ-009 req_addr  in  3x16  per-requester byte address.
REQ-010 req_data  in  3x8  per-requester pixel byte.
REQ-011 req_last  in  3  final beat of the requester's phase.
REQ-012 req_ready  out  3  grant; at most one bit set.
REQ-013 req_start  out  3  one-cycle pulse telling a requester its phase has begun.
REQ-014 addrWrite  out  16  to vga_ram addrWrite.
REQ-015 dataWrite  out  8  to vga_ram dataWrite.
REQ-016 frame_done  out  1  high while in DONE.
REQ-017 overrun  out  1  sticky flag: a swap arrived before DONE.
REQ-018 range_err  out  1  sticky flag: a beat address fell outside its phase region.

Function
REQ-019 The state machine SHALL have the states IDLE, MAZE, SPRITE, SCORE and DONE, with one phase active at a time.
REQ-020 A swap SHALL be detected as buf_sel != buf_sel_q, where buf_sel_q is buf_sel registered.
REQ-021 On a swap in any state, the next state SHALL be MAZE and req_start[0] SHALL pulse in that first MAZE cycle.
REQ-022 A swap in MAZE, SPRITE or SCORE SHALL set overrun; a swap in IDLE or DONE SHALL NOT.
REQ-023 Phase order SHALL be MAZE, then SPRITE, then SCORE, then DONE; DONE holds until the next swap.
REQ-024 Entering SPRITE or SCORE SHALL pulse req_start[1] or req_start[2] respectively for the first cycle of that phase.
REQ-025 req_ready[i] SHALL be high iff the state is phase i and no swap is detected in the current cycle; it is combinational from state and swap.
REQ-026 A beat SHALL be accepted when req_valid[i] and req_ready[i] are both high.
REQ-027 An accepted beat with req_last set SHALL advance the phase on the next cycle.
REQ-028 An accepted beat SHALL appear on addrWrite and dataWrite exactly 1 cycle later (registered).
REQ-029 In any cycle with no accepted beat, addrWrite SHALL be IDLE_ADDR and dataWrite SHALL be 0.
REQ-030 Range check: MAZE beats SHALL have address < MAZE_END; SCORE beats SHALL have MAZE_END <= address < SCORE_END; SPRITE beats SHALL have address < MAZE_END.
REQ-031 A beat failing the range check SHALL still be accepted, SHALL be written to IDLE_ADDR instead of its own address, and SHALL set range_err.
REQ-032 A phase SHALL remain active indefinitely while req_valid is low, with no timeout.
REQ-033 A requester SHALL NOT be granted outside its phase; req_valid outside the phase SHALL be ignored.

Reset
REQ-034 rst SHALL force state to IDLE, buf_sel_q to buf_sel, req_ready and req_start to 0, addrWrite to IDLE_ADDR, dataWrite to 0, and frame_done, overrun and range_err to 0.
REQ-035 rst asserted mid-phase SHALL abandon the phase, and the first swap after reset SHALL restart at MAZE.

Structure
REQ-036 Package vga_pkg SHALL hold the phase enum (IDLE, MAZE, SPRITE, SCORE, DONE) and the address constants 63360, 63808 and 16'hFFFF, shared with vga_ram.
REQ-037 The per-phase address window check SHALL be one sub-module, vga_wr_range_chk, which is purely combinational: inputs phase and addr, output ok.

Verification
REQ-038 Reset then a buf_sel 0->1 edge -> state MAZE next cycle, req_start=3'b001, req_ready=3'b001, no overrun.
REQ-039 Maze beats addr 0..3, data 8'h11..8'h14, last on addr 3 -> addrWrite 0..3 each 1 cycle later, then SPRITE with req_start=3'b010.
REQ-040 Complete all three phases (score addr 63360) -> frame_done=1 and addrWrite=16'hFFFF while idle; the next swap clears frame_done with no overrun.
REQ-041 Swap while SPRITE is pending -> req_ready=0 in the swap cycle, overrun=1, MAZE restarts with req_start=3'b001.
REQ-042 Score beat at addr 100 -> addrWrite=16'hFFFF next cycle, range_err=1, and the phase still advances on last.
REQ-043 rst asserted mid-MAZE with valid high -> state IDLE, all flags 0, and no write reaches the RAM at addr < 16'hFFFF.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared frame-drawing definitions: phase encoding and frame RAM address map.
// Used by the draw scheduler and the frame RAM.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAZE,
    SPRITE,
    SCORE,
    DONE
  } phase_e;

  localparam logic [15:0] MAZE_END_ADDR  = 16'd63360;
  localparam logic [15:0] SCORE_END_ADDR = 16'd63808;
  localparam logic [15:0] IDLE_WR_ADDR   = 16'hFFFF;
  localparam int          NUM_REQ        = 3;

  function automatic logic is_phase(phase_e ph);
    return (ph == MAZE) || (ph == SPRITE) || (ph == SCORE);
  endfunction

  // Requester index owning a phase; non-drawing states map to 0 and are never granted.
  function automatic logic [1:0] phase_idx(phase_e ph);
    case (ph)
      SPRITE:  return 2'd1;
      SCORE:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_draw_sched_if.sv
// Requester bundle: per-requester beat valid/addr/data/last plus grant and phase-start pulses.
interface vga_draw_sched_if;
  import vga_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][15:0] req_addr;
  logic [NUM_REQ-1:0][7:0]  req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_start;

  modport master (
    output req_valid, req_addr, req_data, req_last,
    input  req_ready, req_start
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_last,
    output req_ready, req_start
  );

endinterface

// File: rtl/vga_wr_range_chk.sv
// Combinational check that a beat address lies inside the region its phase may draw.
module vga_wr_range_chk
  import vga_pkg::*;
#(
  parameter logic [15:0] MAZE_END  = MAZE_END_ADDR,
  parameter logic [15:0] SCORE_END = SCORE_END_ADDR
) (
  input  phase_e      phase,
  input  logic [15:0] addr,
  output logic        ok
);

  always_comb begin
    ok = 1'b0;
    case (phase)
      MAZE, SPRITE: ok = (addr < MAZE_END);
      SCORE:        ok = (addr >= MAZE_END) && (addr < SCORE_END);
      default:      ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/vga_draw_sched.sv
// Sequences maze, sprite and score drawing into the frame RAM once per buffer swap.
// One requester granted at a time; accepted beats reach the RAM one cycle later.
module vga_draw_sched
  import vga_pkg::*;
#(
  parameter logic [15:0] IDLE_ADDR = IDLE_WR_ADDR,
  parameter logic [15:0] MAZE_END  = MAZE_END_ADDR,
  parameter logic [15:0] SCORE_END = SCORE_END_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_sel,
  vga_draw_sched_if.slave   req,
  output logic [15:0]       addrWrite,
  output logic [7:0]        dataWrite,
  output logic              frame_done,
  output logic              overrun,
  output logic              range_err
);

  phase_e      state_q, state_d;
  logic        buf_sel_q;
  logic [2:0]  start_q, start_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        overrun_q, overrun_d;
  logic        range_err_q, range_err_d;

  logic        swap;
  logic        in_phase;
  logic [1:0]  idx;
  logic [2:0]  ready;
  logic        accept;
  logic        addr_ok;
  logic [15:0] beat_addr;
  logic [7:0]  beat_data;
  logic        beat_last;

  vga_wr_range_chk #(
    .MAZE_END  (MAZE_END),
    .SCORE_END (SCORE_END)
  ) u_range_chk (
    .phase (state_q),
    .addr  (beat_addr),
    .ok    (addr_ok)
  );

  always_comb begin
    swap      = (buf_sel != buf_sel_q);
    in_phase  = is_phase(state_q);
    idx       = phase_idx(state_q);
    beat_addr = req.req_addr[idx];
    beat_data = req.req_data[idx];
    beat_last = req.req_last[idx];

    // A swap pre-empts the current phase, so nothing is granted in that cycle.
    ready = '0;
    if (in_phase && !swap && !rst) ready[idx] = 1'b1;
    accept = |(ready & req.req_valid);

    state_d = state_q;
    if (swap) begin
      state_d = MAZE;
    end else if (accept && beat_last) begin
      case (state_q)
        MAZE:    state_d = SPRITE;
        SPRITE:  state_d = SCORE;
        SCORE:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end

    start_d = '0;
    if ((swap || (state_d != state_q)) && is_phase(state_d)) start_d[phase_idx(state_d)] = 1'b1;

    // Out-of-window beats are diverted to the scratch byte rather than dropped.
    addr_d = IDLE_ADDR;
    data_d = '0;
    if (accept) begin
      addr_d = addr_ok ? beat_addr : IDLE_ADDR;
      data_d = beat_data;
    end

    overrun_d   = overrun_q | (swap & in_phase);
    range_err_d = range_err_q | (accept & ~addr_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_sel_q   <= buf_sel;
      start_q     <= '0;
      addr_q      <= IDLE_ADDR;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_sel_q   <= buf_sel;
      start_q     <= start_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      range_err_q <= range_err_d;
    end
  end

  assign req.req_ready = ready;
  assign req.req_start = rst ? 3'b000 : start_q;
  assign addrWrite     = rst ? IDLE_ADDR : addr_q;
  assign dataWrite     = rst ? 8'h00 : data_q;
  assign frame_done    = !rst && (state_q == DONE);
  assign overrun       = !rst && overrun_q;
  assign range_err     = !rst && range_err_q;

endmodule

// File: tb/tb_vga_draw_sched.sv
// Bench for vga_draw_sched: directed frame scenarios plus a randomized run against a phase-level model.
module tb_vga_draw_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_sel;
  logic [15:0] addrWrite;
  logic [7:0]  dataWrite;
  logic        frame_done;
  logic        overrun;
  logic        range_err;

  int n_tests = 0;
  int n_fail  = 0;

  vga_draw_sched_if bus ();

  vga_draw_sched dut (
    .clk        (clk),
    .rst        (rst),
    .buf_sel    (buf_sel),
    .req        (bus),
    .addrWrite  (addrWrite),
    .dataWrite  (dataWrite),
    .frame_done (frame_done),
    .overrun    (overrun),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic drive_beat(input int r, input logic [15:0] a, input logic [7:0] d, input logic l);
    clear_reqs();
    bus.req_valid[r] = 1'b1;
    bus.req_addr[r]  = a;
    bus.req_data[r]  = d;
    bus.req_last[r]  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    buf_sel = 1'b0;
    clear_reqs();
    cyc();
    cyc();
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    n_tests++; if (bus.req_start !== 3'b000) begin n_fail++; $display("FAIL reset_start got=%b exp=000", bus.req_start); end
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr got=%h exp=ffff", addrWrite); end
    n_tests++; if (dataWrite !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", dataWrite); end
    n_tests++; if ({frame_done, overrun, range_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {frame_done, overrun, range_err}); end
    rst = 1'b0;
    cyc();
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready got=%b exp=000", bus.req_ready); end
  endtask

  task automatic test_start();
    buf_sel = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL start_swapcyc_ready got=%b exp=000", bus.req_ready); end
    cyc();
    n_tests++; if (bus.req_start !== 3'b001) begin n_fail++; $display("FAIL start_pulse got=%b exp=001", bus.req_start); end
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL start_ready got=%b exp=001", bus.req_ready); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL start_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_maze_beats();
    for (int i = 0; i < 4; i++) begin
      drive_beat(0, 16'(i), 8'(8'h11 + i), (i == 3));
      #1;
      n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL maze_ready beat=%0d got=%b exp=001", i, bus.req_ready); end
      cyc();
      if (i == 3) clear_reqs();
      #1;
      n_tests++; if (addrWrite !== 16'(i)) begin n_fail++; $display("FAIL maze_addr beat=%0d got=%h exp=%h", i, addrWrite, 16'(i)); end
      n_tests++; if (dataWrite !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL maze_data beat=%0d got=%h exp=%h", i, dataWrite, 8'(8'h11 + i)); end
    end
    n_tests++; if (bus.req_start !== 3'b010) begin n_fail++; $display("FAIL sprite_start got=%b exp=010", bus.req_start); end
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL sprite_ready got=%b exp=010", bus.req_ready); end
    cyc();
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL maze_idle_addr got=%h exp=ffff", addrWrite); end
    n_tests++; if (dataWrite !== 8'h00) begin n_fail++; $display("FAIL maze_idle_data got=%h exp=00", dataWrite); end
    n_tests++; if (bus.req_start !== 3'b000) begin n_fail++; $display("FAIL sprite_start_once got=%b exp=000", bus.req_start); end
  endtask

  task automatic test_full_frame();
    drive_beat(1, 16'h0100, 8'hAA, 1'b1);
    cyc();
    clear_reqs();
    #1;
    n_tests++; if (addrWrite !== 16'h0100) begin n_fail++; $display("FAIL sprite_addr got=%h exp=0100", addrWrite); end
    n_tests++; if (bus.req_start !== 3'b100) begin n_fail++; $display("FAIL score_start got=%b exp=100", bus.req_start); end
    n_tests++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL score_ready got=%b exp=100", bus.req_ready); end
    drive_beat(2, 16'd63360, 8'h55, 1'b1);
    cyc();
    clear_reqs();
    #1;
    n_tests++; if (addrWrite !== 16'd63360) begin n_fail++; $display("FAIL score_addr got=%0d exp=63360", addrWrite); end
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done got=%b exp=1", frame_done); end
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL done_ready got=%b exp=000", bus.req_ready); end
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL score_range_ok got=%b exp=0", range_err); end
    repeat (3) cyc();
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_hold got=%b exp=1", frame_done); end
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL done_addr got=%h exp=ffff", addrWrite); end
    buf_sel = ~buf_sel;
    #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL done_swap_ready got=%b exp=000", bus.req_ready); end
    cyc();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_clear got=%b exp=0", frame_done); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL done_swap_overrun got=%b exp=0", overrun); end
    n_tests++; if (bus.req_start !== 3'b001) begin n_fail++; $display("FAIL restart_start got=%b exp=001", bus.req_start); end
  endtask

  task automatic test_overrun();
    drive_beat(0, 16'd5, 8'h01, 1'b1);
    cyc();
    clear_reqs();
    cyc();
    drive_beat(1, 16'd9, 8'h02, 1'b1);
    buf_sel = ~buf_sel;
    #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL ovr_swap_ready got=%b exp=000", bus.req_ready); end
    cyc();
    clear_reqs();
    #1;
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    n_tests++; if (bus.req_start !== 3'b001) begin n_fail++; $display("FAIL ovr_restart got=%b exp=001", bus.req_start); end
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL ovr_ready got=%b exp=001", bus.req_ready); end
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL ovr_no_write got=%h exp=ffff", addrWrite); end
  endtask

  task automatic test_range_err();
    drive_beat(0, 16'd10, 8'h03, 1'b1);
    cyc();
    drive_beat(1, 16'd20, 8'h04, 1'b1);
    cyc();
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL rng_before got=%b exp=0", range_err); end
    drive_beat(2, 16'd100, 8'h77, 1'b1);
    cyc();
    clear_reqs();
    #1;
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL rng_addr got=%h exp=ffff", addrWrite); end
    n_tests++; if (dataWrite !== 8'h77) begin n_fail++; $display("FAIL rng_data got=%h exp=77", dataWrite); end
    n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL rng_flag got=%b exp=1", range_err); end
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL rng_advance got=%b exp=1", frame_done); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid_phase();
    buf_sel = ~buf_sel;
    cyc();
    drive_beat(0, 16'd7, 8'h99, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=000", bus.req_ready); end
    n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_addr got=%h exp=ffff", addrWrite); end
    cyc();
    n_tests++; if ({frame_done, overrun, range_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got=%b exp=000", {frame_done, overrun, range_err}); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle_ready k=%0d got=%b exp=000", k, bus.req_ready); end
      n_tests++; if (addrWrite !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_idle_addr k=%0d got=%h exp=ffff", k, addrWrite); end
    end
    clear_reqs();
    buf_sel = ~buf_sel;
    cyc();
    n_tests++; if (bus.req_start !== 3'b001) begin n_fail++; $display("FAIL rstmid_restart got=%b exp=001", bus.req_start); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
  endtask

  // Model: ph is the active phase number (0 maze, 1 sprite, 2 score, 3 done, 4 idle).
  task automatic test_random();
    int          ph;
    int          nph;
    logic        prev_buf;
    logic        swap;
    logic        acc;
    logic        ok;
    logic [15:0] a;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_start;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_ovr;
    logic        exp_rerr;

    rst = 1'b1;
    clear_reqs();
    cyc();
    rst = 1'b0;
    ph = 4; prev_buf = buf_sel; exp_start = '0;
    exp_addr = 16'hFFFF; exp_data = '0; exp_ovr = 1'b0; exp_rerr = 1'b0;

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) buf_sel = ~buf_sel;
      for (int j = 0; j < 3; j++) begin
        bus.req_valid[j] = 1'($urandom_range(0, 1));
        bus.req_last[j]  = ($urandom_range(0, 3) == 0);
        bus.req_data[j]  = 8'($urandom);
        case ($urandom_range(0, 2))
          0:       bus.req_addr[j] = 16'($urandom_range(0, 63359));
          1:       bus.req_addr[j] = 16'($urandom_range(63360, 63807));
          default: bus.req_addr[j] = 16'($urandom_range(63808, 65535));
        endcase
      end
      #1;
      swap = (buf_sel != prev_buf);
      exp_ready = (ph < 3 && !swap) ? 3'(1 << ph) : 3'b000;

      n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
      n_tests++; if (bus.req_start !== exp_start) begin n_fail++; $display("FAIL rnd_start c=%0d got=%b exp=%b", c, bus.req_start, exp_start); end
      n_tests++; if (addrWrite !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, addrWrite, exp_addr); end
      n_tests++; if (dataWrite !== exp_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, dataWrite, exp_data); end
      n_tests++; if (frame_done !== (ph == 3)) begin n_fail++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, frame_done, (ph == 3)); end
      n_tests++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL rnd_overrun c=%0d got=%b exp=%b", c, overrun, exp_ovr); end
      n_tests++; if (range_err !== exp_rerr) begin n_fail++; $display("FAIL rnd_range c=%0d got=%b exp=%b", c, range_err, exp_rerr); end

      acc = (ph < 3) && !swap && bus.req_valid[ph];
      exp_addr = 16'hFFFF;
      exp_data = 8'h00;
      if (acc) begin
        a  = bus.req_addr[ph];
        ok = (ph == 2) ? (a >= 16'd63360 && a < 16'd63808) : (a < 16'd63360);
        exp_addr = ok ? a : 16'hFFFF;
        exp_data = bus.req_data[ph];
        if (!ok) exp_rerr = 1'b1;
      end
      if (swap && ph < 3) exp_ovr = 1'b1;
      if (swap) nph = 0;
      else if (acc && bus.req_last[ph]) nph = ph + 1;
      else nph = ph;
      exp_start = ((swap || nph != ph) && nph < 3) ? 3'(1 << nph) : 3'b000;
      ph = nph;
      prev_buf = buf_sel;
      cyc();
    end
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_start();
    test_maze_beats();
    test_full_frame();
    test_overrun();
    test_range_err();
    test_reset_mid_phase();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
